// File: rtl/ghost_if.sv
`default_nettype none
// ghost_if: game-side bundle for the ghost engine (Pac-Man position and wall map in,
// ghost position/direction and catch flag out).
interface ghost_if;
    logic        move_en;
    logic [9:0]  pm_xpos;
    logic [9:0]  pm_ypos;
    logic [0:63] wall_map;
    logic [9:0]  ghost_xpos;
    logic [9:0]  ghost_ypos;
    logic [3:0]  ghost_direction;
    logic        caught;

    modport master (
        output move_en, pm_xpos, pm_ypos, wall_map,
        input  ghost_xpos, ghost_ypos, ghost_direction, caught
    );

    modport slave (
        input  move_en, pm_xpos, pm_ypos, wall_map,
        output ghost_xpos, ghost_ypos, ghost_direction, caught
    );
endinterface
`default_nettype wire

// File: rtl/ghost_controller.sv
`default_nettype none
// ghost_controller: walks one ghost tile-to-tile over the 8x8 maze, steering toward
// Pac-Man at each tile centre and latching a sticky catch flag on collision.
module ghost_controller #(
    parameter int ORIGIN_X      = 150,
    parameter int ORIGIN_Y      = 34,
    parameter int TILE          = 60,
    parameter int STEP          = 2,
    parameter int START_COL     = 3,
    parameter int START_ROW     = 3,
    parameter int RELEASE_DELAY = 32,
    parameter int COLLIDE       = 30
) (
    input  logic   clk,
    input  logic   rst,
    ghost_if.slave bus
);
    localparam int                STEPS   = TILE / STEP;
    localparam int                RW      = $clog2(RELEASE_DELAY + 1);
    localparam int                SW      = $clog2(STEPS + 1);
    localparam logic [9:0]        SPAWN_X = 10'(ORIGIN_X + TILE * START_COL + TILE / 2);
    localparam logic [9:0]        SPAWN_Y = 10'(ORIGIN_Y + TILE * START_ROW + TILE / 2);
    localparam logic [9:0]        STEP_PX = 10'(STEP);
    localparam logic signed [10:0] CWIN   = 11'(COLLIDE);

    localparam logic [3:0]  DIR_UP     = 4'b1000;
    localparam logic [3:0]  DIR_DOWN   = 4'b0100;
    localparam logic [3:0]  DIR_LEFT   = 4'b0010;
    localparam logic [3:0]  DIR_RIGHT  = 4'b0001;
    localparam logic [15:0] SCAN_ORDER = {DIR_UP, DIR_LEFT, DIR_DOWN, DIR_RIGHT};

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_DECIDE = 2'd1;
    localparam logic [1:0] ST_MOVE   = 2'd2;
    localparam logic [1:0] ST_CAUGHT = 2'd3;

    logic [1:0]    state, state_next;
    logic [RW-1:0] rel_cnt;
    logic [SW-1:0] step_cnt;
    logic [2:0]    gcol, grow;
    logic [9:0]    gx, gy;
    logic [3:0]    dir;
    logic          caught_q;

    // Pac-Man tile via threshold comparisons; negative offsets fall through to 0
    logic signed [10:0] pm_dx, pm_dy;
    logic [2:0]         pm_col, pm_row;
    assign pm_dx = $signed({1'b0, bus.pm_xpos}) - $signed(11'(ORIGIN_X));
    assign pm_dy = $signed({1'b0, bus.pm_ypos}) - $signed(11'(ORIGIN_Y));

    always_comb begin
        pm_col = 3'd0;
        pm_row = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (pm_dx >= $signed(11'(TILE * k))) pm_col = 3'(k);
            if (pm_dy >= $signed(11'(TILE * k))) pm_row = 3'(k);
        end
    end

    logic signed [3:0] dcol, drow;
    logic [3:0]        adcol, adrow;
    assign dcol  = $signed({1'b0, pm_col}) - $signed({1'b0, gcol});
    assign drow  = $signed({1'b0, pm_row}) - $signed({1'b0, grow});
    assign adcol = dcol[3] ? 4'(-dcol) : 4'(dcol);
    assign adrow = drow[3] ? 4'(-drow) : 4'(drow);

    logic [3:0] open_dirs;
    always_comb begin
        open_dirs    = 4'b0000;
        open_dirs[3] = (grow != 3'd0) && !bus.wall_map[{grow - 3'd1, gcol}];
        open_dirs[2] = (grow != 3'd7) && !bus.wall_map[{grow + 3'd1, gcol}];
        open_dirs[1] = (gcol != 3'd0) && !bus.wall_map[{grow, gcol - 3'd1}];
        open_dirs[0] = (gcol != 3'd7) && !bus.wall_map[{grow, gcol + 3'd1}];
    end

    logic [3:0] h_dir, v_dir, first_dir, second_dir, rev_dir, pick;
    logic       first_ok, second_ok, found;
    always_comb begin
        h_dir   = dcol[3] ? DIR_LEFT : DIR_RIGHT;
        v_dir   = drow[3] ? DIR_UP : DIR_DOWN;
        rev_dir = {dir[2], dir[3], dir[0], dir[1]};
        if (adcol >= adrow) begin
            first_dir  = h_dir;
            first_ok   = (dcol != 4'sd0);
            second_dir = v_dir;
            second_ok  = (drow != 4'sd0);
        end else begin
            first_dir  = v_dir;
            first_ok   = (drow != 4'sd0);
            second_dir = h_dir;
            second_ok  = (dcol != 4'sd0);
        end
        pick  = 4'b0000;
        found = 1'b0;
        if (first_ok && |(first_dir & open_dirs)) begin
            pick  = first_dir;
            found = 1'b1;
        end
        if (!found && second_ok && |(second_dir & open_dirs)) begin
            pick  = second_dir;
            found = 1'b1;
        end
        for (int i = 3; i >= 0; i--) begin
            if (!found && (SCAN_ORDER[i*4 +: 4] != rev_dir) && |(SCAN_ORDER[i*4 +: 4] & open_dirs)) begin
                pick  = SCAN_ORDER[i*4 +: 4];
                found = 1'b1;
            end
        end
        // Reversing is allowed only as the last resort
        if (!found && |(rev_dir & open_dirs)) pick = rev_dir;
    end

    logic signed [10:0] cdx, cdy;
    logic               hit;
    assign cdx = $signed({1'b0, gx}) - $signed({1'b0, bus.pm_xpos});
    assign cdy = $signed({1'b0, gy}) - $signed({1'b0, bus.pm_ypos});
    assign hit = (cdx < CWIN) && (cdx > -CWIN) && (cdy < CWIN) && (cdy > -CWIN);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_WAIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT:   if (rel_cnt == RW'(RELEASE_DELAY - 1)) state_next = ST_DECIDE;
            ST_DECIDE: if (hit) state_next = ST_CAUGHT;
                       else if (pick != 4'b0000) state_next = ST_MOVE;
            ST_MOVE:   if (hit) state_next = ST_CAUGHT;
                       else if (bus.move_en && step_cnt == SW'(STEPS - 1)) state_next = ST_DECIDE;
            default:   state_next = ST_CAUGHT;
        endcase
    end

    logic wait_tick, latch_dir, step_tick, arrive, set_caught;
    always_comb begin
        wait_tick  = 1'b0;
        latch_dir  = 1'b0;
        step_tick  = 1'b0;
        arrive     = 1'b0;
        set_caught = 1'b0;
        case (state)
            ST_WAIT:   wait_tick = 1'b1;
            ST_DECIDE: if (hit) set_caught = 1'b1;
                       else latch_dir = 1'b1;
            ST_MOVE:   if (hit) set_caught = 1'b1;
                       else if (bus.move_en) begin
                           step_tick = 1'b1;
                           arrive    = (step_cnt == SW'(STEPS - 1));
                       end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rel_cnt  <= '0;
            step_cnt <= '0;
            gcol     <= 3'(START_COL);
            grow     <= 3'(START_ROW);
            gx       <= SPAWN_X;
            gy       <= SPAWN_Y;
            dir      <= 4'b0000;
            caught_q <= 1'b0;
        end else begin
            if (wait_tick)  rel_cnt  <= rel_cnt + RW'(1);
            if (latch_dir)  dir      <= pick;
            if (set_caught) caught_q <= 1'b1;
            if (step_tick) begin
                case (dir)
                    DIR_UP:    gy <= gy - STEP_PX;
                    DIR_DOWN:  gy <= gy + STEP_PX;
                    DIR_LEFT:  gx <= gx - STEP_PX;
                    DIR_RIGHT: gx <= gx + STEP_PX;
                    default:   ;
                endcase
                if (arrive) begin
                    step_cnt <= '0;
                    case (dir)
                        DIR_UP:    grow <= grow - 3'd1;
                        DIR_DOWN:  grow <= grow + 3'd1;
                        DIR_LEFT:  gcol <= gcol - 3'd1;
                        DIR_RIGHT: gcol <= gcol + 3'd1;
                        default:   ;
                    endcase
                end else begin
                    step_cnt <= step_cnt + SW'(1);
                end
            end
        end
    end

    assign bus.ghost_xpos      = gx;
    assign bus.ghost_ypos      = gy;
    assign bus.ghost_direction = dir;
    assign bus.caught          = caught_q;
endmodule
`default_nettype wire

// File: tb/tb_ghost_controller.sv
`default_nettype none
// tb_ghost_controller: directed maze scenarios; a tile-level ghost model is compared
// against the DUT every cycle, plus hand-computed spot values.
module tb_ghost_controller;
    logic clk = 1'b0;
    logic rst;
    ghost_if bus();

    ghost_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tile coordinates plus pixels travelled toward the next tile
    int         m_phase;   // 0 waiting, 1 deciding, 2 moving, 3 caught
    int         m_cnt, m_col, m_row, m_trav, m_caught;
    logic [3:0] m_dir;
    bit         m_valid = 0;

    function automatic int vx(input logic [3:0] d);
        return (d == 4'b0001) ? 1 : (d == 4'b0010) ? -1 : 0;
    endfunction

    function automatic int vy(input logic [3:0] d);
        return (d == 4'b0100) ? 1 : (d == 4'b1000) ? -1 : 0;
    endfunction

    function automatic int model_x();
        return 150 + 60 * m_col + 30 + vx(m_dir) * m_trav;
    endfunction

    function automatic int model_y();
        return 34 + 60 * m_row + 30 + vy(m_dir) * m_trav;
    endfunction

    function automatic int to_tile(input int p, input int org);
        int t;
        if (p < org) return 0;
        t = (p - org) / 60;
        return (t > 7) ? 7 : t;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [3:0] choose();
        logic [3:0] q[$];
        logic [3:0] order[4];
        logic [3:0] h, v, rev;
        int dc, dr, c, r;
        order = '{4'b1000, 4'b0010, 4'b0100, 4'b0001};
        dc  = to_tile(int'(bus.pm_xpos), 150) - m_col;
        dr  = to_tile(int'(bus.pm_ypos), 34) - m_row;
        h   = (dc > 0) ? 4'b0001 : 4'b0010;
        v   = (dr > 0) ? 4'b0100 : 4'b1000;
        rev = (m_dir == 4'b1000) ? 4'b0100 : (m_dir == 4'b0100) ? 4'b1000 :
              (m_dir == 4'b0010) ? 4'b0001 : (m_dir == 4'b0001) ? 4'b0010 : 4'b0000;
        if (iabs(dc) >= iabs(dr)) begin
            if (dc != 0) q.push_back(h);
            if (dr != 0) q.push_back(v);
        end else begin
            if (dr != 0) q.push_back(v);
            if (dc != 0) q.push_back(h);
        end
        foreach (order[i]) if (order[i] != rev) q.push_back(order[i]);
        if (rev != 4'b0000) q.push_back(rev);
        foreach (q[i]) begin
            c = m_col + vx(q[i]);
            r = m_row + vy(q[i]);
            if (c >= 0 && c < 8 && r >= 0 && r < 8 && !bus.wall_map[r * 8 + c]) return q[i];
        end
        return 4'b0000;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_col = 3; m_row = 3;
            m_trav = 0; m_dir = 4'b0000; m_caught = 0; m_valid = 1;
        end else if (m_valid) begin
            case (m_phase)
                0: begin
                    m_cnt++;
                    if (m_cnt == 32) m_phase = 1;
                end
                1, 2: begin
                    if (iabs(model_x() - int'(bus.pm_xpos)) < 30 &&
                        iabs(model_y() - int'(bus.pm_ypos)) < 30) begin
                        m_caught = 1;
                        m_phase  = 3;
                    end else if (m_phase == 1) begin
                        m_dir = choose();
                        if (m_dir != 4'b0000) m_phase = 2;
                    end else if (bus.move_en) begin
                        m_trav += 2;
                        if (m_trav == 60) begin
                            m_col  += vx(m_dir);
                            m_row  += vy(m_dir);
                            m_trav  = 0;
                            m_phase = 1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_xpos",   int'(bus.ghost_xpos), model_x());
            chk("model_ypos",   int'(bus.ghost_ypos), model_y());
            chk("model_dir",    int'(bus.ghost_direction), int'(m_dir));
            chk("model_caught", int'(bus.caught), m_caught);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.move_en  = 1'b1;
        bus.pm_xpos  = 10'd540;
        bus.pm_ypos  = 10'd244;
        bus.wall_map = '0;
        tick(2);
        chk("reset_x", int'(bus.ghost_xpos), 360);
        chk("reset_y", int'(bus.ghost_ypos), 244);
        chk("reset_dir", int'(bus.ghost_direction), 0);
        chk("reset_caught", int'(bus.caught), 0);
        rst = 1'b0;
        tick(31);
        chk("wait_frozen_x", int'(bus.ghost_xpos), 360);
        chk("wait_dir", int'(bus.ghost_direction), 0);
        tick(2);
        chk("open_dir_right", int'(bus.ghost_direction), 1);
        tick(30);
        chk("open_arrive_x", int'(bus.ghost_xpos), 420);
        chk("open_arrive_y", int'(bus.ghost_ypos), 244);

        rst = 1'b1;
        bus.wall_map[28] = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(33);
        chk("wall_dir_up", int'(bus.ghost_direction), 8);
        tick(1);
        chk("wall_y_step1", int'(bus.ghost_ypos), 242);
        tick(1);
        chk("wall_y_step2", int'(bus.ghost_ypos), 240);

        rst = 1'b1;
        bus.wall_map[19] = 1'b1;
        bus.wall_map[26] = 1'b1;
        bus.wall_map[35] = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(33);
        chk("boxed_dir", int'(bus.ghost_direction), 0);
        tick(5);
        chk("boxed_dir_later", int'(bus.ghost_direction), 0);
        chk("boxed_x", int'(bus.ghost_xpos), 360);
        chk("boxed_y", int'(bus.ghost_ypos), 244);
        bus.wall_map[28] = 1'b0;
        tick(2);
        chk("unboxed_dir", int'(bus.ghost_direction), 1);
        tick(3);
        chk("unboxed_x", int'(bus.ghost_xpos), 368);
        bus.pm_xpos = 10'd380;
        tick(1);
        chk("catch_flag", int'(bus.caught), 1);
        chk("catch_x", int'(bus.ghost_xpos), 368);
        tick(100);
        chk("catch_hold", int'(bus.caught), 1);
        chk("catch_hold_x", int'(bus.ghost_xpos), 368);
        chk("catch_hold_dir", int'(bus.ghost_direction), 1);

        rst = 1'b1;
        bus.wall_map = '0;
        bus.pm_xpos  = 10'd540;
        tick(1);
        chk("rst_clears_caught", int'(bus.caught), 0);
        rst = 1'b0;
        tick(38);
        chk("move_x", int'(bus.ghost_xpos), 370);
        bus.move_en = 1'b0;
        tick(10);
        chk("stall_x", int'(bus.ghost_xpos), 370);
        rst = 1'b1;
        tick(1);
        chk("midtile_rst_x", int'(bus.ghost_xpos), 360);
        chk("midtile_rst_y", int'(bus.ghost_ypos), 244);
        chk("midtile_rst_dir", int'(bus.ghost_direction), 0);
        chk("midtile_rst_caught", int'(bus.caught), 0);
        rst = 1'b0;
        bus.move_en = 1'b1;
        bus.pm_xpos = 10'd100;
        bus.pm_ypos = 10'd20;
        tick(31);
        chk("rewait_x", int'(bus.ghost_xpos), 360);
        chk("rewait_dir", int'(bus.ghost_direction), 0);
        tick(2);
        chk("clamp_tie_left", int'(bus.ghost_direction), 2);
        tick(4);
        chk("clamp_left_x", int'(bus.ghost_xpos), 352);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
